imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles the bytes into 32-bit big-endian MIPS instruction words, and drives the write port of a writable instruction RAM from word address 0 upward.
- Holds the CPU (stall/reset request) until the image is complete, so the fetch path only ever reads a finished program.

Parameters:
- DEPTH, 256, number of 32-bit words in the instruction RAM.
- ADDR_W, 8, word-address width; must equal clog2(DEPTH).
- BOOT_HOLD, 1, value of cpu_hold after reset (1 = CPU held until the first load completes).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction RAM write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  instruction word to write.
- cpu_hold  out  1  CPU must stall/hold PC at 0.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully (sticky).
- error  out  1  last load aborted on a bad length (sticky).
- word_cnt  out  ADDR_W+1  number of words written in the current/last load.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - State to IDLE.
  - rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, word_cnt=0.
  - cpu_hold=BOOT_HOLD.
  - A reset mid-load aborts immediately: no further writes, and the partial image is left in the RAM.
- Byte transfer: a byte transfers on a rising edge where rx_valid && rx_ready. rx_data is ignored otherwise.
- Stream format:
  - Bytes 0-1: word count N, 16-bit big-endian.
  - Then 4*N instruction bytes, each word MSB first (first byte goes to wr_data[31:24]).
- State IDLE:
  - rx_ready=0; outputs hold their last status.
  - On start: clear done, error and word_cnt; set busy=1 and cpu_hold=1; go to LEN_HI.
- State LEN_HI: rx_ready=1. On transfer, store N[15:8] and go to LEN_LO.
- State LEN_LO: rx_ready=1. On transfer, store N[7:0], then:
  - If N==0 or N>DEPTH, go to ERR.
  - Otherwise clear the byte index and go to BYTE.
- State BYTE:
  - rx_ready=1. Each transfer shifts the byte into the 32-bit assembly register and increments the 2-bit byte index.
  - On the 4th byte (index 3), go to WRITE.
- State WRITE (exactly one cycle):
  - rx_ready=0, wr_en=1, wr_addr=word index, wr_data=assembled word.
  - word_cnt increments on this edge.
  - If the word index equals N-1, go to DONE; otherwise increment the word index and go to BYTE.
- Write latency: wr_en asserts in the cycle after the 4th byte's transfer edge.
- Throughput: at most 4 bytes per 5 cycles.
- State DONE: busy=0, done=1, cpu_hold=0, rx_ready=0. Go to IDLE on the next cycle; done stays sticky.
- State ERR: busy=0, error=1, cpu_hold=1 (a CPU never runs a bad image), rx_ready=0. Go to IDLE on the next cycle; error stays sticky.
- start while busy is ignored. A new start from IDLE after DONE or ERR starts a fresh load.
- rx_valid stalls are unbounded; there is no timeout. The state and byte index hold while rx_valid=0.
- Word index wrap: impossible, because N<=DEPTH is checked. word_cnt is ADDR_W+1 bits so it can represent DEPTH.
- wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Shared package mips_pkg holds:
  - The loader state enum (IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE, ERR).
  - INSTR_W=32.
  - IMEM_DEPTH=256, which is also used by the instruction RAM.
- Natural sub-module: imem_word_packer. It contains the byte shift register plus the 2-bit index, with inputs shift_en and clear, and outputs word and full.
- The FSM, counters and status flags stay in imem_loader.

Test Plan:
- Reset, then start, then stream 00 02, 20 01 00 04, 20 22 00 02 with rx_valid held high. Required: two wr_en pulses, (addr 0, data 0x20010004) then (addr 1, data 0x20220002). After that, done=1, cpu_hold=0, word_cnt=2.
- Same stream, but rx_valid toggles 1/0 every cycle. Required: identical writes, wr_en pulses exactly 2 times, no byte lost or duplicated.
- Length 00 00 → error=1, cpu_hold=1, no wr_en. Length 01 01 (257) with DEPTH=256 → error=1, no wr_en.
- Assert rst mid-stream after 2 of 4 bytes of word 1. Required: outputs at reset values immediately (async), no wr_en. A subsequent full load of 1 word 0x08000005 writes addr 0 and sets done=1.
- Pulse start during BYTE state. Required: ignored; the load completes normally with the same writes.
- Full-depth load of N=256 with word value = address. Required: the last write is addr 255, data 0x000000FF, word_cnt=256, done=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, instruction RAM depth and the
// boot loader state encoding.
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int IMEM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    BYTE   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Shifts incoming bytes MSB-first into a 32-bit instruction word and tracks
// how many bytes of the current word have arrived.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               full
);

  logic [INSTR_W-1:0] word_r;
  logic [1:0]         idx_r;

  // Byte shift register and byte index; clear wins over a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r <= '0;
      idx_r  <= 2'd0;
    end else if (clear) begin
      word_r <= '0;
      idx_r  <= 2'd0;
    end else if (shift_en) begin
      word_r <= {word_r[INSTR_W-9:0], byte_in};
      idx_r  <= idx_r + 2'd1;
    end else begin
      word_r <= word_r;
      idx_r  <= idx_r;
    end
  end

  assign word = word_r;
  assign full = (idx_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: length-prefixed big-endian byte stream in,
// one RAM word write per four bytes out, CPU held until a good image is loaded.
module imem_loader
  import mips_pkg::*;
#(
  parameter int   DEPTH     = IMEM_DEPTH,
  parameter int   ADDR_W    = 8,
  parameter logic BOOT_HOLD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_cnt
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t      state_r, state_next;
  logic [15:0]        len_r;
  logic [15:0]        len_new;
  logic [ADDR_W-1:0]  word_idx_r;
  logic [ADDR_W-1:0]  wr_addr_r;
  logic [INSTR_W-1:0] wr_data_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic               busy_r, done_r, error_r, cpu_hold_r;
  logic               xfer, last_word, len_bad;
  logic [INSTR_W-1:0] pack_word;
  logic               pack_full;

  assign rx_ready  = (state_r == LEN_HI) || (state_r == LEN_LO) || (state_r == BYTE);
  assign xfer      = rx_valid && rx_ready;
  assign len_new   = {len_r[15:8], rx_data};
  assign len_bad   = (len_new == 16'd0) || (len_new > 16'(DEPTH));
  assign last_word = (16'(word_idx_r) == (len_r - 16'd1));

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (xfer && (state_r == BYTE)),
    .clear    ((state_r == LEN_LO) && xfer),
    .byte_in  (rx_data),
    .word     (pack_word),
    .full     (pack_full)
  );

  // Next-state decode.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:   if (start) state_next = LEN_HI; else state_next = IDLE;
      LEN_HI: if (xfer) state_next = LEN_LO; else state_next = LEN_HI;
      LEN_LO: begin
        if (xfer) begin
          if (len_bad) state_next = ERR; else state_next = BYTE;
        end else begin
          state_next = LEN_LO;
        end
      end
      BYTE:   if (xfer && pack_full) state_next = WRITE; else state_next = BYTE;
      WRITE:  if (last_word) state_next = DONE; else state_next = BYTE;
      DONE:   state_next = IDLE;
      ERR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, length, word index and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      len_r      <= 16'd0;
      word_idx_r <= '0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      word_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_hold_r <= BOOT_HOLD;
    end else begin
      state_r <= state_next;
      case (state_r)
        IDLE: begin
          if (start) begin
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            word_cnt_r <= '0;
            word_idx_r <= '0;
            busy_r     <= 1'b1;
            cpu_hold_r <= 1'b1;
          end
        end
        LEN_HI: if (xfer) len_r[15:8] <= rx_data;
        LEN_LO: begin
          if (xfer) begin
            len_r[7:0] <= rx_data;
            if (len_bad) begin
              busy_r     <= 1'b0;
              error_r    <= 1'b1;
              cpu_hold_r <= 1'b1;
            end
          end
        end
        BYTE: if (xfer && pack_full) wr_addr_r <= word_idx_r;
        WRITE: begin
          wr_data_r  <= pack_word;
          word_cnt_r <= word_cnt_r + CNT_W'(1);
          if (last_word) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end else begin
            word_idx_r <= word_idx_r + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The packer holds the finished word through WRITE; afterwards the copy
  // taken on that cycle keeps wr_data stable while the next word assembles.
  assign wr_en    = (state_r == WRITE);
  assign wr_addr  = wr_addr_r;
  assign wr_data  = (state_r == WRITE) ? pack_word : wr_data_r;
  assign cpu_hold = cpu_hold_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected RAM writes are queued as bytes are
// sent and checked against each wr_en pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold, busy, done, error;
  logic [8:0]  word_cnt;

  int total = 0;
  int bad   = 0;
  int wr_pulses = 0;
  logic [7:0]  last_addr;
  logic [31:0] last_data;
  logic [39:0] sb[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each write strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_pulses++;
      last_addr = wr_addr;
      last_data = wr_data;
      if (sb.size() == 0) begin
        chk("unexpected_write", {24'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = sb.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[39:32]});
        chk("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("rx_ready_timeout", 32'd0, 32'd1);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      rx_data = 8'hXX;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input bit gap);
    sb.push_back({addr, w});
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_timeout", {31'd0, (t < 100)}, 32'd1);
  endtask

  task automatic two_word_load(input bit gap);
    int p0;
    p0 = wr_pulses;
    pulse_start();
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(8'd0, 32'h2001_0004, gap);
    send_word(8'd1, 32'h2022_0002, gap);
    wait_idle();
    chk("two_pulses", wr_pulses - p0, 32'd2);
    chk("sb_empty", sb.size(), 32'd0);
    chk("done", {31'd0, done}, 32'd1);
    chk("error", {31'd0, error}, 32'd0);
    chk("cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("word_cnt", {23'd0, word_cnt}, 32'd2);
  endtask

  task automatic bad_len_load(input logic [7:0] hi, input logic [7:0] lo);
    int p0;
    p0 = wr_pulses;
    pulse_start();
    send_byte(hi, 1'b0);
    send_byte(lo, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_done", {31'd0, done}, 32'd0);
    chk("err_hold", {31'd0, cpu_hold}, 32'd1);
    chk("err_no_write", wr_pulses - p0, 32'd0);
    chk("err_ready", {31'd0, rx_ready}, 32'd0);
  endtask

  initial begin
    int p0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_word_cnt", {23'd0, word_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);

    two_word_load(1'b0);
    two_word_load(1'b1);

    bad_len_load(8'h00, 8'h00);
    bad_len_load(8'h01, 8'h01);

    // Reset in the middle of the second word.
    p0 = wr_pulses;
    pulse_start();
    chk("busy_set", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(8'd0, 32'h1234_5678, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("arst_ready", {31'd0, rx_ready}, 32'd0);
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk("arst_error", {31'd0, error}, 32'd0);
    chk("arst_word_cnt", {23'd0, word_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("arst_writes", wr_pulses - p0, 32'd1);
    chk("arst_sb", sb.size(), 32'd0);

    p0 = wr_pulses;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(8'd0, 32'h0800_0005, 1'b0);
    wait_idle();
    chk("reload_writes", wr_pulses - p0, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_cnt", {23'd0, word_cnt}, 32'd1);

    // start pulse while a word is being assembled must be ignored.
    p0 = wr_pulses;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    sb.push_back({8'd0, 32'h2001_0004});
    send_byte(8'h20, 1'b0);
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(8'd1, 32'h2022_0002, 1'b0);
    wait_idle();
    chk("ign_writes", wr_pulses - p0, 32'd2);
    chk("ign_sb", sb.size(), 32'd0);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_cnt", {23'd0, word_cnt}, 32'd2);

    // Full-depth image, word value equals its address.
    p0 = wr_pulses;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) send_word(8'(i), 32'(i), 1'b0);
    wait_idle();
    chk("full_writes", wr_pulses - p0, 32'd256);
    chk("full_last_addr", {24'd0, last_addr}, 32'd255);
    chk("full_last_data", last_data, 32'h0000_00FF);
    chk("full_cnt", {23'd0, word_cnt}, 32'd256);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_hold", {31'd0, cpu_hold}, 32'd0);
    chk("full_sb", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
